packet_assembler: RTL and testbench

Destination-side reassembly stage that consumes the byte-serial flit stream produced by the per-node splitter after it crosses the network. Collects the four byte flits of each 32-bit packet per source node, tolerates interleaving between sources, and presents completed words through a small output FIFO with a valid/ready handshake to the local core.

---
 rtl/packet_assembler.sv | 158 +++++++++++++++
 tb/tb_packet_assembler.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/packet_assembler.sv
`default_nettype none
// ============================================================================
// Module   : packet_assembler
// Brief    : Per-source reassembly of byte flits into 32-bit words, with FIFO.
// Revision : 1.0 - initial release
// ============================================================================
module packet_assembler #(
  parameter  int NODE_ID         = 0,
  parameter  int NODE_COUNT      = 8,
  parameter  int PACKET_ID_WIDTH = 5,
  parameter  int OUT_DEPTH       = 4,
  localparam int NW              = $clog2(NODE_COUNT),
  localparam int PW              = PACKET_ID_WIDTH,
  localparam int FW              = 1 + 2*NW + 8 + PW + 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          ce,
  input  logic [FW-1:0] flit_in,
  input  logic          flit_valid,
  output logic [31:0]   out_data,
  output logic [NW-1:0] out_src,
  output logic [PW-1:0] out_id,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          err,
  output logic [7:0]    drop_count
);

  localparam int            c_aw    = $clog2(OUT_DEPTH);
  localparam int            c_ew    = NW + PW + 32;
  localparam logic [NW-1:0] c_node  = NODE_ID[NW-1:0];
  localparam logic [c_aw:0] c_depth = OUT_DEPTH[c_aw:0];

  // Flit fields
  logic          w_fv;
  logic [NW-1:0] w_dest;
  logic [7:0]    w_byte;
  logic [PW-1:0] w_id;
  logic [NW-1:0] w_src;
  logic [1:0]    w_idx;

  assign w_fv   = flit_in[FW-1];
  assign w_dest = flit_in[FW-2 -: NW];
  assign w_byte = flit_in[FW-2-NW -: 8];
  assign w_id   = flit_in[NW+2 +: PW];
  assign w_src  = flit_in[2 +: NW];
  assign w_idx  = flit_in[1:0];

  // Assembly slots, one per source node
  logic [31:0]   r_acc  [NODE_COUNT];
  logic [3:0]    r_mask [NODE_COUNT];
  logic [PW-1:0] r_id   [NODE_COUNT];

  logic          w_accept;
  logic [3:0]    w_cur_mask;
  logic [31:0]   w_cur_acc;
  logic [PW-1:0] w_cur_id;
  logic [3:0]    w_bit;
  logic          w_id_hit;
  logic          w_fresh;
  logic [31:0]   w_base_acc;
  logic [4:0]    w_shift;
  logic [31:0]   w_acc_next;
  logic [3:0]    w_mask_next;
  logic          w_err;
  logic          w_complete;

  always_comb begin
    w_accept    = ce && flit_valid && w_fv && (w_dest == c_node);
    w_cur_mask  = r_mask[w_src];
    w_cur_acc   = r_acc[w_src];
    w_cur_id    = r_id[w_src];
    w_bit       = 4'b0001 << w_idx;
    w_id_hit    = (w_cur_id == w_id);
    // An empty slot or a new id restarts the packet from this flit alone
    w_fresh     = (w_cur_mask == 4'b0000) || !w_id_hit;
    w_base_acc  = w_fresh ? 32'h0 : w_cur_acc;
    w_shift     = {w_idx, 3'b000};
    w_acc_next  = (w_base_acc & ~(32'hFF00_0000 >> w_shift)) | ({w_byte, 24'h0} >> w_shift);
    w_mask_next = w_fresh ? w_bit : (w_cur_mask | w_bit);
    w_err       = w_accept && (w_cur_mask != 4'b0000) &&
                  (!w_id_hit || ((w_cur_mask & w_bit) != 4'b0000));
    w_complete  = w_accept && (w_mask_next == 4'b1111);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NODE_COUNT; i++) begin
        r_acc[i]  <= '0;
        r_mask[i] <= '0;
        r_id[i]   <= '0;
      end
    end else if (w_accept) begin
      r_acc[w_src]  <= w_acc_next;
      r_id[w_src]   <= w_id;
      r_mask[w_src] <= w_complete ? 4'b0000 : w_mask_next;
    end
  end

  // Output FIFO; pointers carry one extra wrap bit
  logic [c_ew-1:0] r_mem [OUT_DEPTH];
  logic [c_aw:0]   r_wptr;
  logic [c_aw:0]   r_rptr;
  logic [c_aw:0]   w_count;
  logic            w_empty;
  logic            w_full;
  logic            w_pop;
  logic            w_push;
  logic            w_drop;
  logic [c_ew-1:0] w_head;
  logic            r_err;
  logic [7:0]      r_drop;

  assign w_count = r_wptr - r_rptr;
  assign w_empty = (r_wptr == r_rptr);
  assign w_full  = (w_count == c_depth);
  assign w_pop   = ce && !w_empty && out_ready;
  assign w_push  = w_complete && (!w_full || w_pop);
  assign w_drop  = w_complete && w_full && !w_pop;
  assign w_head  = r_mem[r_rptr[c_aw-1:0]];

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wptr[c_aw-1:0]] <= {w_src, w_id, w_acc_next};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_err  <= 1'b0;
      r_drop <= 8'h00;
    end else begin
      // w_err already includes ce, so a frozen cycle clears any pulse
      r_err <= w_err;
      if (w_push) begin
        r_wptr <= r_wptr + 1'b1;
      end
      if (w_pop) begin
        r_rptr <= r_rptr + 1'b1;
      end
      if (w_drop && (r_drop != 8'hFF)) begin
        r_drop <= r_drop + 8'h01;
      end
    end
  end

  assign out_valid  = !w_empty;
  assign out_data   = out_valid ? w_head[31:0]       : 32'h0;
  assign out_id     = out_valid ? w_head[32 +: PW]   : '0;
  assign out_src    = out_valid ? w_head[32+PW +: NW] : '0;
  assign err        = r_err;
  assign drop_count = r_drop;

endmodule
`default_nettype wire

// File: tb/tb_packet_assembler.sv
`default_nettype none
// ============================================================================
// Module   : tb_packet_assembler
// Brief    : Scoreboard bench for packet_assembler with NODE_ID = 3.
// Revision : 1.0 - initial release
// ============================================================================
module tb_packet_assembler;
  localparam int NW = 3;
  localparam int PW = 5;
  localparam int FW = 1 + 2*NW + 8 + PW + 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          ce = 1'b1;
  logic [FW-1:0] flit_in = '0;
  logic          flit_valid = 1'b0;
  logic          out_ready = 1'b1;
  logic [31:0]   out_data;
  logic [NW-1:0] out_src;
  logic [PW-1:0] out_id;
  logic          out_valid;
  logic          err;
  logic [7:0]    drop_count;

  always #5 clk = ~clk;

  packet_assembler #(
    .NODE_ID(3), .NODE_COUNT(8), .PACKET_ID_WIDTH(5), .OUT_DEPTH(4)
  ) dut (
    .clk(clk), .rst_n(rst_n), .ce(ce), .flit_in(flit_in), .flit_valid(flit_valid),
    .out_data(out_data), .out_src(out_src), .out_id(out_id), .out_valid(out_valid),
    .out_ready(out_ready), .err(err), .drop_count(drop_count)
  );

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [39:0] exp_q[$];

  task automatic check(input string name, input logic [39:0] act, input logic [39:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push_exp(input logic [2:0] src, input logic [4:0] id, input logic [31:0] w);
    exp_q.push_back({src, id, w});
  endtask

  task automatic send(input logic fv, input logic [2:0] dest, input logic [7:0] data,
                      input logic [4:0] id, input logic [2:0] src, input logic [1:0] idx);
    flit_in    = {fv, dest, data, id, src, idx};
    flit_valid = 1'b1;
    @(posedge clk);
    #1;
    flit_valid = 1'b0;
    flit_in    = '0;
  endtask

  task automatic send_word(input logic [2:0] src, input logic [4:0] id, input logic [31:0] w);
    for (int i = 0; i < 4; i++) send(1'b1, 3'd3, w[31-8*i -: 8], id, src, 2'(i));
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Monitor: every accepted head is matched against the scoreboard
  always @(negedge clk) begin
    if (rst_n && ce && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_output: got %0h expected none", {out_src, out_id, out_data});
      end else begin
        check("fifo_head", {out_src, out_id, out_data}, exp_q.pop_front());
      end
    end
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs", {out_valid, err, drop_count, out_src, out_id, out_data[26:0]}, 40'h0);
    check("reset_data", 40'(out_data), 40'h0);
    rst_n = 1'b1;
    idle(2);

    // Straight-through packet, latency and err quiet
    push_exp(3'd1, 5'd5, 32'hDEAD_BEEF);
    send(1'b1, 3'd3, 8'hDE, 5'd5, 3'd1, 2'd0);
    send(1'b1, 3'd3, 8'hAD, 5'd5, 3'd1, 2'd1);
    send(1'b1, 3'd3, 8'hBE, 5'd5, 3'd1, 2'd2);
    check("no_early_valid", 40'(out_valid), 40'h0);
    send(1'b1, 3'd3, 8'hEF, 5'd5, 3'd1, 2'd3);
    check("latency_valid", 40'(out_valid), 40'h1);
    check("err_quiet", 40'(err), 40'h0);
    idle(2);

    // Interleaved sources, out-of-order bytes
    push_exp(3'd6, 5'd9, 32'hAABB_CCDD);
    push_exp(3'd2, 5'd2, 32'h1122_3344);
    send(1'b1, 3'd3, 8'h11, 5'd2, 3'd2, 2'd0);
    send(1'b1, 3'd3, 8'hDD, 5'd9, 3'd6, 2'd3);
    send(1'b1, 3'd3, 8'h33, 5'd2, 3'd2, 2'd2);
    send(1'b1, 3'd3, 8'hAA, 5'd9, 3'd6, 2'd0);
    send(1'b1, 3'd3, 8'hBB, 5'd9, 3'd6, 2'd1);
    send(1'b1, 3'd3, 8'h22, 5'd2, 3'd2, 2'd1);
    send(1'b1, 3'd3, 8'hCC, 5'd9, 3'd6, 2'd2);
    send(1'b1, 3'd3, 8'h44, 5'd2, 3'd2, 2'd3);
    check("interleave_err", 40'(err), 40'h0);
    idle(3);

    // Id change mid-packet restarts the slot
    send(1'b1, 3'd3, 8'h01, 5'd4, 3'd1, 2'd0);
    send(1'b1, 3'd3, 8'h02, 5'd4, 3'd1, 2'd1);
    check("err_before_mismatch", 40'(err), 40'h0);
    send(1'b1, 3'd3, 8'hCA, 5'd7, 3'd1, 2'd0);
    check("err_id_mismatch", 40'(err), 40'h1);
    idle(1);
    check("err_one_cycle", 40'(err), 40'h0);
    push_exp(3'd1, 5'd7, 32'hCAFE_BABE);
    send(1'b1, 3'd3, 8'hFE, 5'd7, 3'd1, 2'd1);
    send(1'b1, 3'd3, 8'hBA, 5'd7, 3'd1, 2'd2);
    send(1'b1, 3'd3, 8'hBE, 5'd7, 3'd1, 2'd3);
    idle(2);

    // Duplicate byte index overwrites and flags
    send(1'b1, 3'd3, 8'h12, 5'd3, 3'd5, 2'd0);
    send(1'b1, 3'd3, 8'h34, 5'd3, 3'd5, 2'd0);
    check("err_duplicate", 40'(err), 40'h1);
    push_exp(3'd5, 5'd3, 32'h3456_789A);
    send(1'b1, 3'd3, 8'h56, 5'd3, 3'd5, 2'd1);
    check("err_dup_cleared", 40'(err), 40'h0);
    send(1'b1, 3'd3, 8'h78, 5'd3, 3'd5, 2'd2);
    send(1'b1, 3'd3, 8'h9A, 5'd3, 3'd5, 2'd3);
    idle(2);

    // Overflow: six words into a depth-4 FIFO with consumer stalled
    out_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (i < 4) push_exp(3'd0, 5'(i), 32'hA0B0_C0D0 + 32'(i));
      send_word(3'd0, 5'(i), 32'hA0B0_C0D0 + 32'(i));
    end
    check("drop_count_2", 40'(drop_count), 40'h2);
    check("overflow_err_quiet", 40'(err), 40'h0);
    idle(3);
    check("head_held", {out_src, out_id, out_data}, {3'd0, 5'd0, 32'hA0B0_C0D0});
    out_ready = 1'b1;
    idle(6);
    check("drained_four", 40'(out_valid), 40'h0);

    // Push and pop in the same cycle on a full FIFO: no drop
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      push_exp(3'd7, 5'(10 + i), 32'h0F0E_0D00 + 32'(i));
      send_word(3'd7, 5'(10 + i), 32'h0F0E_0D00 + 32'(i));
    end
    push_exp(3'd7, 5'd20, 32'h5566_7788);
    send(1'b1, 3'd3, 8'h55, 5'd20, 3'd7, 2'd0);
    send(1'b1, 3'd3, 8'h66, 5'd20, 3'd7, 2'd1);
    send(1'b1, 3'd3, 8'h77, 5'd20, 3'd7, 2'd2);
    out_ready = 1'b1;
    send(1'b1, 3'd3, 8'h88, 5'd20, 3'd7, 2'd3);
    check("full_pushpop_no_drop", 40'(drop_count), 40'h2);
    idle(8);
    check("pushpop_drained", 40'(out_valid), 40'h0);

    // Foreign dest, invalid flit bit and ce low are all ignored
    for (int i = 0; i < 4; i++) send(1'b1, 3'd2, 8'hEE, 5'd9, 3'd1, 2'(i));
    for (int i = 0; i < 4; i++) send(1'b0, 3'd3, 8'hEE, 5'd9, 3'd1, 2'(i));
    ce = 1'b0;
    for (int i = 0; i < 4; i++) send(1'b1, 3'd3, 8'hEE, 5'd9, 3'd2, 2'(i));
    ce = 1'b1;
    idle(3);
    check("ignored_no_output", {38'h0, out_valid, err}, 40'h0);
    push_exp(3'd1, 5'd9, 32'h1357_9BDF);
    send(1'b1, 3'd3, 8'h9B, 5'd9, 3'd1, 2'd2);
    send(1'b1, 3'd3, 8'h13, 5'd9, 3'd1, 2'd0);
    send(1'b1, 3'd3, 8'hDF, 5'd9, 3'd1, 2'd3);
    check("ignored_no_err", 40'(err), 40'h0);
    send(1'b1, 3'd3, 8'h57, 5'd9, 3'd1, 2'd1);
    idle(3);

    // Reset mid-packet with a queued word
    out_ready = 1'b0;
    send_word(3'd3, 5'd2, 32'h2468_1357);
    send(1'b1, 3'd3, 8'h55, 5'd1, 3'd4, 2'd0);
    send(1'b1, 3'd3, 8'h66, 5'd1, 3'd4, 2'd1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midreset_outputs", {out_valid, err, drop_count, out_src, out_id, out_data[26:0]}, 40'h0);
    check("midreset_data", 40'(out_data), 40'h0);
    idle(2);
    rst_n = 1'b1;
    out_ready = 1'b1;
    idle(1);
    send(1'b1, 3'd3, 8'h03, 5'd1, 3'd4, 2'd2);
    send(1'b1, 3'd3, 8'h04, 5'd1, 3'd4, 2'd3);
    check("postreset_no_stale", 40'(out_valid), 40'h0);
    push_exp(3'd4, 5'd1, 32'h0102_0304);
    send(1'b1, 3'd3, 8'h01, 5'd1, 3'd4, 2'd0);
    send(1'b1, 3'd3, 8'h02, 5'd1, 3'd4, 2'd1);
    idle(5);

    check("scoreboard_empty", 40'(exp_q.size()), 40'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
